vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 Hz VGA output path, upstream of every sprite and background renderer. It produces the `DrawX`/`DrawY` scan coordinates and the active-high `blank` (display-enable) qualifier that renderers use to address their ROMs. It also produces the monitor `hs`/`vs` strobes, both raw and delayed, so that the sync pulses line up with the renderers' registered RGB. A frame-end pulse and frame counter are provided for game-logic tick generation.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, coordinate type and derived-total helpers
// for the VGA raster generator and the renderers that consume its coordinates.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    typedef logic [9:0] coord_t;

    function automatic int h_total(int visible, int fp, int sync, int bp);
        return visible + fp + sync + bp;
    endfunction

    function automatic int v_total(int visible, int fp, int sync, int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Single-bit shift-register delay that lines the sync strobes up with the
// renderers' registered RGB; DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_shift
        logic [DEPTH-1:0] stages;

        // NOTE: every delay stage is reset so the connector sees inactive sync right out of reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stages <= {DEPTH{RESET_VAL}};
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan counters, display-enable, raw and pipeline-aligned
// sync strobes, plus a frame-end tick and completed-frame counter.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int PIPE_DLY  = 2,
    parameter int FC_W      = 16
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    output logic [9:0]      DrawX,
    output logic [9:0]      DrawY,
    output logic            blank,
    output logic            hs,
    output logic            vs,
    output logic            hs_d,
    output logic            vs_d,
    output logic            frame_end,
    output logic [FC_W-1:0] frame_count
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;

    // NOTE: defaults first so no path through the block leaves a value held (no latch).
    always_comb begin
        x_next = DrawX + coord_t'(1);
        y_next = DrawY;
        if (DrawX == H_LAST) begin
            x_next = '0;
            y_next = (DrawY == V_LAST) ? coord_t'(0) : DrawY + coord_t'(1);
        end
    end

    // Qualifiers decode the next counter values so they land on the same edge as the counters.
    // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_end   <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX     <= x_next;
            DrawY     <= y_next;
            blank     <= (x_next < H_VIS) && (y_next < V_VIS);
            hs        <= !((x_next >= HS_START) && (x_next <= HS_END));
            vs        <= !((y_next >= VS_START) && (y_next <= VS_END));
            frame_end <= (x_next == H_LAST) && (y_next == V_LAST);
            if (frame_end) begin
                frame_count <= frame_count + FC_W'(1);
            end
        end
    end

    vga_sync_delay #(
        .DEPTH    (PIPE_DLY),
        .RESET_VAL(1'b1)
    ) u_hs_delay (
        .clk  (vga_clk),
        .rst_n(reset_n),
        .d    (hs),
        .q    (hs_d)
    );

    vga_sync_delay #(
        .DEPTH    (PIPE_DLY),
        .RESET_VAL(1'b1)
    ) u_vs_delay (
        .clk  (vga_clk),
        .rst_n(reset_n),
        .d    (vs),
        .q    (vs_d)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two shrunken rasters
// (sync delay 2 and 0, 2-bit frame counter), all against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int dly; int fcw;
    } cfg_t;

    typedef struct packed {
        int x; int y; int fc;
        bit blank; bit hs; bit vs; bit hs_d; bit vs_d; bit fe;
    } exp_t;

    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;

    localparam cfg_t CFG_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 16};
    localparam cfg_t CFG_S2  = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 2, 2};
    localparam cfg_t CFG_S0  = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, 2};

    logic clk = 1'b0;
    logic reset_n;
    int   n;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    // Edges seen since the last reset release; the raster position is a pure function of it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    logic [9:0]  d_x, d_y, s2_x, s2_y, s0_x, s0_y;
    logic        d_b, d_hs, d_vs, d_hsd, d_vsd, d_fe;
    logic        s2_b, s2_hs, s2_vs, s2_hsd, s2_vsd, s2_fe;
    logic        s0_b, s0_hs, s0_vs, s0_hsd, s0_vsd, s0_fe;
    logic [15:0] d_fc;
    logic [1:0]  s2_fc, s0_fc;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_b),
        .hs(d_hs), .vs(d_vs), .hs_d(d_hsd), .vs_d(d_vsd), .frame_end(d_fe), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DLY(2), .FC_W(2)
    ) u_s2 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(s2_x), .DrawY(s2_y), .blank(s2_b),
        .hs(s2_hs), .vs(s2_vs), .hs_d(s2_hsd), .vs_d(s2_vsd), .frame_end(s2_fe), .frame_count(s2_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DLY(0), .FC_W(2)
    ) u_s0 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(s0_x), .DrawY(s0_y), .blank(s0_b),
        .hs(s0_hs), .vs(s0_vs), .hs_d(s0_hsd), .vs_d(s0_vsd), .frame_end(s0_fe), .frame_count(s0_fc)
    );

    function automatic bit hs_at(cfg_t c, int k);
        int ht = c.hv + c.hf + c.hsw + c.hb;
        int x  = k % ht;
        return !((x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw));
    endfunction

    function automatic bit vs_at(cfg_t c, int k);
        int ht = c.hv + c.hf + c.hsw + c.hb;
        int vt = c.vv + c.vf + c.vsw + c.vb;
        int y  = (k / ht) % vt;
        return !((y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw));
    endfunction

    function automatic exp_t model(cfg_t c, int k);
        exp_t e;
        int ht = c.hv + c.hf + c.hsw + c.hb;
        int vt = c.vv + c.vf + c.vsw + c.vb;
        e.x     = k % ht;
        e.y     = (k / ht) % vt;
        e.blank = (e.x < c.hv) && (e.y < c.vv);
        e.hs    = hs_at(c, k);
        e.vs    = vs_at(c, k);
        e.hs_d  = (k < c.dly) ? 1'b1 : hs_at(c, k - c.dly);
        e.vs_d  = (k < c.dly) ? 1'b1 : vs_at(c, k - c.dly);
        e.fe    = (e.x == ht - 1) && (e.y == vt - 1);
        e.fc    = (k / (ht * vt)) % (1 << c.fcw);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    task automatic cmp(string nm, cfg_t c, logic [9:0] dx, logic [9:0] dy, logic b,
                       logic h, logic v, logic hd, logic vd, logic fe, logic [15:0] fc);
        exp_t e = model(c, n);
        check({nm, ".DrawX"},       32'(dx), e.x);
        check({nm, ".DrawY"},       32'(dy), e.y);
        check({nm, ".blank"},       32'(b),  32'(e.blank));
        check({nm, ".hs"},          32'(h),  32'(e.hs));
        check({nm, ".vs"},          32'(v),  32'(e.vs));
        check({nm, ".hs_d"},        32'(hd), 32'(e.hs_d));
        check({nm, ".vs_d"},        32'(vd), 32'(e.vs_d));
        check({nm, ".frame_end"},   32'(fe), 32'(e.fe));
        check({nm, ".frame_count"}, 32'(fc), e.fc);
    endtask

    task automatic check_all();
        cmp("def", CFG_DEF, d_x,  d_y,  d_b,  d_hs,  d_vs,  d_hsd,  d_vsd,  d_fe,  d_fc);
        cmp("s2",  CFG_S2,  s2_x, s2_y, s2_b, s2_hs, s2_vs, s2_hsd, s2_vsd, s2_fe, {14'b0, s2_fc});
        cmp("s0",  CFG_S0,  s0_x, s0_y, s0_b, s0_hs, s0_vs, s0_hsd, s0_vsd, s0_fe, {14'b0, s0_fc});
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_all();
        end
        reset_n = 1'b1;

        // Five-plus small frames (2-bit counter wraps) and 2.5 default lines.
        repeat (2000) begin
            @(negedge clk);
            check_all();
        end

        // Asynchronous resets at random raster positions, checked before any further clock edge.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #($urandom_range(1, 3));
            reset_n = 1'b0;
            #1;
            check_all();
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                check_all();
            end
            reset_n = 1'b1;
            repeat ($urandom_range(50, 900)) begin
                @(negedge clk);
                check_all();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
